// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: memory-op encodings, exception codes and the
// memory-stage FSM state type.
package mips_pkg;

  typedef logic [3:0] mem_op_t;

  localparam mem_op_t OP_NONE = 4'd0;
  localparam mem_op_t OP_LW   = 4'd1;
  localparam mem_op_t OP_LH   = 4'd2;
  localparam mem_op_t OP_LHU  = 4'd3;
  localparam mem_op_t OP_LB   = 4'd4;
  localparam mem_op_t OP_LBU  = 4'd5;
  localparam mem_op_t OP_SW   = 4'd6;
  localparam mem_op_t OP_SH   = 4'd7;
  localparam mem_op_t OP_SB   = 4'd8;

  typedef logic [4:0] exc_code_t;

  localparam exc_code_t EXC_NONE = 5'd0;
  localparam exc_code_t EXC_ADEL = 5'd4;
  localparam exc_code_t EXC_ADES = 5'd5;
  localparam exc_code_t EXC_DBE  = 5'd7;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic logic op_is_store(input mem_op_t op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane alignment: store byte-enable/data replication, load
// byte/half extraction with sign or zero extension, and alignment fault detect.
module mem_lane_align
  import mips_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    misaligned = 1'b0;
    be         = '0;
    wdata      = '0;
    rdata_ext  = '0;
    byte_sel   = load_data[{addr_lo, 3'b000} +: 8];
    half_sel   = addr_lo[1] ? load_data[31:16] : load_data[15:0];
    case (op)
      OP_LW: begin
        misaligned = (addr_lo != 2'b00);
        be         = '1;
        rdata_ext  = load_data;
      end
      OP_LH: begin
        misaligned = addr_lo[0];
        be         = '1;
        rdata_ext  = {{16{half_sel[15]}}, half_sel};
      end
      OP_LHU: begin
        misaligned = addr_lo[0];
        be         = '1;
        rdata_ext  = {16'h0000, half_sel};
      end
      OP_LB: begin
        be        = '1;
        rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      end
      OP_LBU: begin
        be        = '1;
        rdata_ext = {24'h000000, byte_sel};
      end
      OP_SW: begin
        misaligned = (addr_lo != 2'b00);
        be         = '1;
        wdata      = store_data;
      end
      OP_SH: begin
        misaligned = addr_lo[0];
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
      end
      OP_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_bus_ctrl.sv
// M-stage data-bus controller: single-outstanding req/ack access with pipeline
// hold. Optional bus timeout (DBE) enabled by defining MEM_TIMEOUT_EN.
module mem_stage_bus_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_M,
  input  logic [3:0]        mem_op_M,
  input  logic [31:0]       aluRet_M,
  input  logic [31:0]       rt_M,
  input  logic [4:0]        excCode_M,
  input  logic              flush_M,
  output logic              stall_M,
  output logic [31:0]       rdata_M,
  output logic [4:0]        excCode_out,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  state_t      state;
  logic [3:0]  op_q;
  logic [1:0]  lo_q;
  logic [4:0]  exc_q;
  logic [31:0] rdata_q;

  logic [3:0]  align_op;
  logic [1:0]  align_lo;
  logic        misaligned;
  logic [3:0]  be_gen;
  logic [31:0] wdata_gen;
  logic [31:0] rdata_ext;
  logic        slot_live;
  logic        accept;
  logic        fault;
  logic        expired;
  logic [4:0]  exc_mux;

  // One aligner serves both directions: current inputs while idle, the
  // latched op/offset while the request is outstanding.
  assign align_op = (state == ST_REQ) ? op_q : mem_op_M;
  assign align_lo = (state == ST_REQ) ? lo_q : aluRet_M[1:0];

  mem_lane_align u_align (
    .op         (align_op),
    .addr_lo    (align_lo),
    .store_data (rt_M),
    .load_data  (bus_rdata),
    .misaligned (misaligned),
    .be         (be_gen),
    .wdata      (wdata_gen),
    .rdata_ext  (rdata_ext)
  );

  assign slot_live = valid_M && (mem_op_M != OP_NONE) && (excCode_M == EXC_NONE)
                     && !flush_M && (state == ST_IDLE);
  assign accept    = slot_live && !misaligned;
  assign fault     = slot_live && misaligned;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if (state == ST_REQ) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign expired = (wait_cnt == 8'(TIMEOUT - 1));
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      op_q      <= OP_NONE;
      lo_q      <= '0;
      exc_q     <= EXC_NONE;
      rdata_q   <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_REQ;
            op_q      <= mem_op_M;
            lo_q      <= aluRet_M[1:0];
            bus_req   <= 1'b1;
            bus_we    <= op_is_store(mem_op_M);
            bus_addr  <= ADDR_W'({aluRet_M[31:2], 2'b00});
            bus_be    <= be_gen;
            bus_wdata <= wdata_gen;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            state   <= ST_DONE;
            bus_req <= 1'b0;
            rdata_q <= rdata_ext;
            exc_q   <= EXC_NONE;
          end else if (expired) begin
            state   <= ST_DONE;
            bus_req <= 1'b0;
            rdata_q <= '0;
            exc_q   <= EXC_DBE;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          rdata_q <= '0;
          exc_q   <= EXC_NONE;
        end
        default: begin
          state   <= ST_IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

  // Upstream exceptions win over alignment faults; DONE reports the bus result.
  always_comb begin
    exc_mux = EXC_NONE;
    if (state == ST_DONE) begin
      exc_mux = exc_q;
    end else if (state == ST_IDLE) begin
      if (excCode_M != EXC_NONE) begin
        exc_mux = excCode_M;
      end else if (fault) begin
        exc_mux = op_is_store(mem_op_M) ? EXC_ADES : EXC_ADEL;
      end
    end
  end

  assign excCode_out = reset ? exc_mux : EXC_NONE;
  assign stall_M     = reset && (accept || (state == ST_REQ));
  assign rdata_M     = rdata_q;

endmodule
